// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the five-stage RV32I pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait freeze with watchdog, and perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  idex_rd,
    input  logic        idex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        fault_clear,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        mem_fault,
    output logic [1:0]  state_out,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FAULT    = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        mw;
    logic        lu;
    logic        at_limit;
    logic        flush_evt;

    assign mw       = dmem_req & ~dmem_ready;
    assign lu       = idex_mem_read & (idex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == idex_rd)) |
                       (id_uses_rs2 & (id_rs2 == idex_rd)));
    assign at_limit = (wait_cnt == 16'(MEM_TIMEOUT));
    assign state_out = state;

    // RUN and the MEM_WAIT release cycle share one resolution path; the only
    // difference is that a wait in MEM_WAIT may trip the watchdog.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        mem_fault  = 1'b0;
        flush_evt  = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state == S_FAULT) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b0;
        end else if (mw) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            mem_fault = (state == S_MEM_WAIT) && at_limit;
        end else if (ex_branch_taken) begin
            // The ID instruction is wrong-path, so any load-use on it is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RUN;
            wait_cnt     <= 16'd0;
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (!pc_en && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_evt && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
            case (state)
                S_RUN: begin
                    if (mw) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mw)
                        state <= S_RUN;
                    else if (at_limit)
                        state <= S_FAULT;
                    else
                        wait_cnt <= wait_cnt + 16'd1;
                end
                S_FAULT: begin
                    if (fault_clear)
                        state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle model of the hazard rules
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_pipeline_hazard_ctrl;

    localparam int T = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, idex_rd;
    logic        id_uses_rs1, id_uses_rs2, idex_mem_read;
    logic        ex_branch_taken, dmem_req, dmem_ready, fault_clear;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic        mem_fault;
    logic [1:0]  state_out;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .fault_clear(fault_clear),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .mem_fault(mem_fault), .state_out(state_out),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] C_NORM  = 7'b1101011;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_LU    = 7'b0001111;
    localparam logic [6:0] C_FLT   = 7'b0111101;
    localparam logic [6:0] C_RST   = 7'b1111111;

    int      m_state = 0;   // 0 RUN, 1 MEM_WAIT, 2 FAULT
    int      m_wait  = 0;
    longint  m_stall = 0;
    int      m_flush = 0;
    bit      started = 0;

    // cls: 0 reset, 1 fault, 2 frozen, 3 branch, 4 load-use, 5 normal
    int         cls;
    logic [6:0] exp_ctl;
    logic       exp_fault;
    always_comb begin
        bit waiting, hazard;
        waiting = dmem_req && !dmem_ready;
        hazard  = idex_mem_read && (idex_rd != 0) &&
                  ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
        if (rst)                  cls = 0;
        else if (m_state == 2)    cls = 1;
        else if (waiting)         cls = 2;
        else if (ex_branch_taken) cls = 3;
        else if (hazard)          cls = 4;
        else                      cls = 5;
        case (cls)
            0:       exp_ctl = C_RST;
            1:       exp_ctl = C_FLT;
            2:       exp_ctl = C_FRZ;
            3:       exp_ctl = C_BR;
            4:       exp_ctl = C_LU;
            default: exp_ctl = C_NORM;
        endcase
        exp_fault = (cls == 2) && (m_state == 1) && (m_wait == T);
    end

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_state <= 0; m_wait <= 0; m_stall <= 0; m_flush <= 0;
        end else begin
            if (!exp_ctl[6] && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
            if (cls == 3 && m_flush < 65535)             m_flush <= m_flush + 1;
            if (m_state == 0 && cls == 2) begin
                m_state <= 1; m_wait <= 1;
            end else if (m_state == 1) begin
                if (cls != 2)        m_state <= 0;
                else if (m_wait == T) m_state <= 2;
                else                 m_wait <= m_wait + 1;
            end else if (m_state == 2 && fault_clear) begin
                m_state <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ctl", {57'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en},
                {57'd0, exp_ctl});
            chk("mem_fault", {63'd0, mem_fault}, {63'd0, exp_fault});
            chk("state_out", {62'd0, state_out}, m_state);
            chk("stall_cycles", {32'd0, stall_cycles}, m_stall);
            chk("flush_count", {48'd0, flush_count}, m_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; idex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; idex_mem_read = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0; fault_clear = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_state", state_out, 0);
        chk("reset_stall", stall_cycles, 0);
        chk("reset_flush", flush_count, 0);
        chk("reset_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
        chk("reset_fault", mem_fault, 0);

        // Load-use on rs2: one bubble
        tick();
        idex_mem_read = 1; idex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        #1;
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_idex_flush", idex_flush, 1);
        tick(); idle(); #1;
        chk("lu_after_pc_en", pc_en, 1);
        chk("lu_stall", stall_cycles, 1);

        // Load into x0 never hazards; nor does a match on an unused operand
        do_reset();
        idex_mem_read = 1; idex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        #1;
        chk("x0_pc_en", pc_en, 1);
        tick();
        idex_mem_read = 1; idex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0; id_rs2 = 3; id_uses_rs2 = 1;
        #1;
        chk("unused_rs1_pc_en", pc_en, 1);
        tick(); idle(); #1;
        chk("x0_stall", stall_cycles, 0);

        // Branch wins over load-use
        do_reset();
        ex_branch_taken = 1; idex_mem_read = 1; idex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1;
        #1;
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_idex_flush", idex_flush, 1);
        chk("br_pc_en", pc_en, 1);
        tick(); idle(); #1;
        chk("br_flush_count", flush_count, 1);
        chk("br_stall", stall_cycles, 0);

        // 4-cycle memory access with a branch parked in EX
        do_reset();
        dmem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_freeze_pc_en", pc_en, 0);
            chk("mw_freeze_flush", ifid_flush, 0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("mw_release_pc_en", pc_en, 1);
        chk("mw_release_flush", ifid_flush, 1);
        chk("mw_release_state", state_out, 1);
        chk("mw_release_stall", stall_cycles, 3);
        tick(); idle(); #1;
        chk("mw_after_state", state_out, 0);
        chk("mw_after_flush", flush_count, 1);
        chk("mw_after_stall", stall_cycles, 3);

        // Watchdog: entry cycle, then wait counter 1,2,3 -> fault at 3
        do_reset();
        dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wd_no_fault", mem_fault, 0);
            tick();
        end
        #1;
        chk("wd_fault", mem_fault, 1);
        chk("wd_fault_state", state_out, 1);
        tick(); #1;
        chk("wd_in_fault_state", state_out, 2);
        chk("wd_no_refault", mem_fault, 0);
        chk("wd_fault_ctl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}, 7'b0111101);
        tick();
        fault_clear = 1;
        #1;
        chk("wd_clear_state", state_out, 2);
        tick(); idle(); #1;
        chk("wd_cleared_state", state_out, 0);
        chk("wd_stall", stall_cycles, 6);

        // Reset in the second wait cycle
        do_reset();
        dmem_req = 1;
        tick();
        rst = 1;
        #1;
        chk("rmw_fault", mem_fault, 0);
        chk("rmw_forced_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
        chk("rmw_forced_flush", {ifid_flush, idex_flush}, 2'b11);
        tick();
        rst = 0; idle();
        #1;
        chk("rmw_state", state_out, 0);
        chk("rmw_stall", stall_cycles, 0);
        chk("rmw_flush", flush_count, 0);

        // Request withdrawn without ready behaves as a release
        dmem_req = 1;
        tick();
        dmem_req = 0;
        #1;
        chk("drop_pc_en", pc_en, 1);
        chk("drop_state", state_out, 1);
        tick(); #1;
        chk("drop_after_state", state_out, 0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
